// File: rtl/unsat_select_controller.sv
// Sequences clause-buffer loading and random unsat-clause selection for the SAT core.
// Optional statistics counters are enabled by defining UNSAT_SELECT_CONTROLLER_STATS_EN.
module unsat_select_controller #(
  parameter int BUFFER_DEPTH          = 2048,
  parameter int NSAT                  = 3,
  parameter int LITERAL_ADDRESS_WIDTH = 12,
  parameter int SELECT_LATENCY        = 4
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    load_start_i,
  input  logic                                    load_valid_i,
  input  logic [$clog2(BUFFER_DEPTH)-1:0]         load_addr_i,
  input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   load_data_i,
  input  logic                                    load_done_i,
  input  logic                                    sel_req_i,
  input  logic                                    sel_ready_i,
  input  logic                                    wd_req_i,
  output logic                                    sel_valid_o,
  output logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   sel_clause_o,
  output logic                                    sat_o,
  output logic                                    overflow_err_o,
  output logic                                    busy_o,
  output logic                                    setup_o,
  output logic                                    ucb_setup_wren_o,
  output logic [$clog2(BUFFER_DEPTH)-1:0]         ucb_setup_addr_o,
  output logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   ucb_setup_data_o,
  output logic                                    request_o,
  output logic                                    write_disable_o,
  input  logic [$clog2(BUFFER_DEPTH)-1:0]         buffer_count_i,
  input  logic                                    ucb_overflow_i,
  input  logic [NSAT*LITERAL_ADDRESS_WIDTH-1:0]   selected_i
`ifdef UNSAT_SELECT_CONTROLLER_STATS_EN
  ,
  output logic [31:0]                             stat_selects_o,
  output logic [15:0]                             stat_sat_o
`endif
);

  localparam int AW   = $clog2(BUFFER_DEPTH);
  localparam int CW   = NSAT * LITERAL_ADDRESS_WIDTH;
  localparam int CNTW = (SELECT_LATENCY > 1) ? $clog2(SELECT_LATENCY) : 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] DRAIN = 3'd2;
  localparam logic [2:0] READY = 3'd3;
  localparam logic [2:0] ISSUE = 3'd4;
  localparam logic [2:0] WAIT  = 3'd5;
  localparam logic [2:0] VALID = 3'd6;
  localparam logic [2:0] SAT   = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   clause_q, clause_d;
  logic            err_q, err_d;
  logic            wren_q, wd_q;
  logic [AW-1:0]   addr_q;
  logic [CW-1:0]   data_q;
  logic            load_accept;

  assign load_accept = load_start_i &&
                       (state_q == IDLE || state_q == READY || state_q == SAT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clause_d = clause_q;
    unique case (state_q)
      IDLE:  if (load_start_i) state_d = LOAD;
      LOAD:  if (load_done_i) state_d = DRAIN;
      DRAIN: state_d = READY;
      READY: begin
        if (load_start_i) state_d = LOAD;
        else if (sel_req_i)
          state_d = (buffer_count_i == '0 && !ucb_overflow_i) ? SAT : ISSUE;
      end
      ISSUE: begin
        cnt_d   = CNTW'(SELECT_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        // Counter reaches zero exactly SELECT_LATENCY cycles after the request cycle.
        if (cnt_q == '0) begin
          clause_d = selected_i;
          state_d  = VALID;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      VALID: if (sel_ready_i) state_d = READY;
      SAT:   if (load_start_i) state_d = LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (ucb_overflow_i)   err_d = 1'b1;
    else if (load_accept) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      clause_q <= '0;
      err_q    <= 1'b0;
      wren_q   <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      wd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clause_q <= clause_d;
      err_q    <= err_d;
      wd_q     <= wd_req_i;
      wren_q   <= (state_q == LOAD) && load_valid_i;
      if (state_q == LOAD && load_valid_i) begin
        addr_q <= load_addr_i;
        data_q <= load_data_i;
      end
    end
  end

  assign setup_o          = (state_q == LOAD) || (state_q == DRAIN);
  assign request_o        = (state_q == ISSUE);
  assign sel_valid_o      = (state_q == VALID);
  assign sat_o            = (state_q == SAT);
  assign busy_o           = (state_q != READY);
  assign sel_clause_o     = clause_q;
  assign overflow_err_o   = err_q;
  assign ucb_setup_wren_o = wren_q;
  assign ucb_setup_addr_o = addr_q;
  assign ucb_setup_data_o = data_q;
  assign write_disable_o  = wd_q && !(state_q == LOAD || state_q == DRAIN ||
                                      state_q == ISSUE || state_q == WAIT);

`ifdef UNSAT_SELECT_CONTROLLER_STATS_EN
  logic [31:0] stat_sel_q;
  logic [15:0] stat_sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_sel_q <= '0;
      stat_sat_q <= '0;
    end else begin
      if (state_q == VALID && sel_ready_i) stat_sel_q <= stat_sel_q + 32'd1;
      if (state_d == SAT && state_q != SAT && stat_sat_q != '1)
        stat_sat_q <= stat_sat_q + 16'd1;
    end
  end

  assign stat_selects_o = stat_sel_q;
  assign stat_sat_o     = stat_sat_q;
`endif

endmodule

// File: tb/tb_unsat_select_controller.sv
// Scenario bench for unsat_select_controller with a fixed-latency selector model and clause scoreboard.
module tb_unsat_select_controller;

  localparam int AW = 11;
  localparam int CW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start_i, load_valid_i, load_done_i;
  logic [AW-1:0] load_addr_i;
  logic [CW-1:0] load_data_i;
  logic          sel_req_i, sel_ready_i, wd_req_i;
  logic          sel_valid_o, sat_o, overflow_err_o, busy_o, setup_o;
  logic [CW-1:0] sel_clause_o;
  logic          ucb_setup_wren_o, request_o, write_disable_o;
  logic [AW-1:0] ucb_setup_addr_o;
  logic [CW-1:0] ucb_setup_data_o;
  logic [AW-1:0] buffer_count_i;
  logic          ucb_overflow_i;
  logic [CW-1:0] selected_i;

  int vectors     = 0;
  int miscompares = 0;
  int req_seen    = 0;

  logic [CW-1:0] exp_q[$];
  logic [CW-1:0] next_clause = '0;
  logic [3:0]    req_pipe;

  always #5 clk = ~clk;

  unsat_select_controller #(
    .BUFFER_DEPTH(2048), .NSAT(3), .LITERAL_ADDRESS_WIDTH(12), .SELECT_LATENCY(4)
  ) dut (
    .clk(clk), .reset(reset),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_addr_i(load_addr_i), .load_data_i(load_data_i), .load_done_i(load_done_i),
    .sel_req_i(sel_req_i), .sel_ready_i(sel_ready_i), .wd_req_i(wd_req_i),
    .sel_valid_o(sel_valid_o), .sel_clause_o(sel_clause_o), .sat_o(sat_o),
    .overflow_err_o(overflow_err_o), .busy_o(busy_o), .setup_o(setup_o),
    .ucb_setup_wren_o(ucb_setup_wren_o), .ucb_setup_addr_o(ucb_setup_addr_o),
    .ucb_setup_data_o(ucb_setup_data_o), .request_o(request_o),
    .write_disable_o(write_disable_o), .buffer_count_i(buffer_count_i),
    .ucb_overflow_i(ucb_overflow_i), .selected_i(selected_i)
  );

  // Selector model: the clause is only valid exactly four cycles after request_o.
  always @(posedge clk) begin
    if (reset) req_pipe <= '0;
    else       req_pipe <= {req_pipe[2:0], request_o};
  end
  assign selected_i = req_pipe[3] ? next_clause : ~next_clause;

  always @(negedge clk) if (request_o === 1'b1) req_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [CW-1:0] clause);
    next_clause = clause;
    exp_q.push_back(clause);
    sel_req_i = 1'b1;
    step();
    sel_req_i = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (sel_valid_o !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic quick_load();
    load_start_i = 1'b1; step(); load_start_i = 1'b0;
    load_done_i  = 1'b1; step(); load_done_i  = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; load_start_i = 1'b1;
    step(); step();
    load_start_i = 1'b0;
    vectors++;
    if ({sel_valid_o, sat_o, overflow_err_o, setup_o, ucb_setup_wren_o, request_o, write_disable_o} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags got %b exp 0000000", {sel_valid_o, sat_o, overflow_err_o, setup_o, ucb_setup_wren_o, request_o, write_disable_o});
    end
    vectors++;
    if (busy_o !== 1'b1) begin miscompares++; $display("FAIL reset_busy got %b exp 1", busy_o); end
    vectors++;
    if (sel_clause_o !== '0 || ucb_setup_data_o !== '0 || ucb_setup_addr_o !== '0) begin
      miscompares++; $display("FAIL reset_data clause %h data %h addr %h exp 0", sel_clause_o, ucb_setup_data_o, ucb_setup_addr_o);
    end
    reset = 1'b0;
    step();
    vectors++;
    if (setup_o !== 1'b0) begin miscompares++; $display("FAIL reset_idle setup got %b exp 0", setup_o); end
  endtask

  task automatic test_load();
    int setup_cycles = 0;
    logic [CW-1:0] d;
    load_start_i = 1'b1; step(); load_start_i = 1'b0;
    if (setup_o === 1'b1) setup_cycles++;
    for (int i = 0; i < 3; i++) begin
      d = CW'(36'hA0000_0000 + 36'(i * 17));
      load_valid_i = 1'b1; load_addr_i = AW'(i); load_data_i = d;
      step();
      load_valid_i = 1'b0;
      if (setup_o === 1'b1) setup_cycles++;
      vectors++;
      if (ucb_setup_wren_o !== 1'b1 || ucb_setup_addr_o !== AW'(i) || ucb_setup_data_o !== d) begin
        miscompares++;
        $display("FAIL load_beat%0d wren %b addr %0d data %h exp 1 %0d %h", i, ucb_setup_wren_o, ucb_setup_addr_o, ucb_setup_data_o, i, d);
      end
    end
    load_done_i = 1'b1; step(); load_done_i = 1'b0;
    if (setup_o === 1'b1) setup_cycles++;
    vectors++;
    if (ucb_setup_wren_o !== 1'b0) begin miscompares++; $display("FAIL drain_wren got %b exp 0", ucb_setup_wren_o); end
    step();
    if (setup_o === 1'b1) setup_cycles++;
    vectors++;
    if (setup_cycles != 5) begin miscompares++; $display("FAIL setup_cycles got %0d exp 5", setup_cycles); end
    vectors++;
    if (busy_o !== 1'b0) begin miscompares++; $display("FAIL ready_busy got %b exp 0", busy_o); end
  endtask

  task automatic test_select();
    int n, r0;
    logic [CW-1:0] e;
    buffer_count_i = AW'(3);
    r0 = req_seen;
    send_req(36'h123456789);
    vectors++;
    if (request_o !== 1'b1 || setup_o !== 1'b0) begin
      miscompares++; $display("FAIL issue_request req %b setup %b exp 1 0", request_o, setup_o);
    end
    wait_valid(n);
    vectors++;
    if (n != 5) begin miscompares++; $display("FAIL select_latency got %0d exp 5", n); end
    vectors++;
    if (req_seen - r0 != 1) begin miscompares++; $display("FAIL request_pulses got %0d exp 1", req_seen - r0); end
    e = exp_q.size() > 0 ? exp_q[0] : '0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sel_valid_o !== 1'b1 || sel_clause_o !== e) begin
        miscompares++; $display("FAIL hold%0d valid %b clause %h exp 1 %h", i, sel_valid_o, sel_clause_o, e);
      end
      step();
    end
    sel_ready_i = 1'b1;
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    vectors++;
    if (sel_clause_o !== e) begin miscompares++; $display("FAIL accept_clause got %h exp %h", sel_clause_o, e); end
    step();
    sel_ready_i = 1'b0;
    vectors++;
    if (sel_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      miscompares++; $display("FAIL after_accept valid %b busy %b exp 0 0", sel_valid_o, busy_o);
    end
  endtask

  task automatic test_write_disable();
    logic [CW-1:0] e;
    buffer_count_i = AW'(5);
    wd_req_i = 1'b1;
    step();
    vectors++;
    if (write_disable_o !== 1'b1) begin miscompares++; $display("FAIL wd_ready got %b exp 1", write_disable_o); end
    send_req(36'hF0F0F0F0F);
    vectors++;
    if (write_disable_o !== 1'b0) begin miscompares++; $display("FAIL wd_issue got %b exp 0", write_disable_o); end
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if (write_disable_o !== 1'b0 || sel_valid_o !== 1'b0) begin
        miscompares++; $display("FAIL wd_wait%0d wd %b valid %b exp 0 0", i, write_disable_o, sel_valid_o);
      end
    end
    step();
    vectors++;
    if (sel_valid_o !== 1'b1 || write_disable_o !== 1'b1) begin
      miscompares++; $display("FAIL wd_valid valid %b wd %b exp 1 1", sel_valid_o, write_disable_o);
    end
    sel_ready_i = 1'b1;
    e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
    vectors++;
    if (sel_clause_o !== e) begin miscompares++; $display("FAIL wd_clause got %h exp %h", sel_clause_o, e); end
    step();
    sel_ready_i = 1'b0; wd_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [CW-1:0] e;
    logic [CW-1:0] clauses [3] = '{36'h000000001, 36'h876543210, 36'hFFFFFFFFE};
    buffer_count_i = AW'(100);
    for (int k = 0; k < 3; k++) begin
      send_req(clauses[k]);
      wait_valid(n);
      sel_ready_i = 1'b1;
      e = exp_q.size() > 0 ? exp_q.pop_front() : '0;
      vectors++;
      if (n != 5 || sel_clause_o !== e) begin
        miscompares++; $display("FAIL b2b%0d latency %0d clause %h exp 5 %h", k, n, sel_clause_o, e);
      end
      step();
      sel_ready_i = 1'b0;
    end
  endtask

  task automatic test_sat();
    int r0;
    buffer_count_i = '0;
    r0 = req_seen;
    sel_req_i = 1'b1; step(); sel_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (sat_o !== 1'b1 || busy_o !== 1'b1) begin
        miscompares++; $display("FAIL sat_hold%0d sat %b busy %b exp 1 1", i, sat_o, busy_o);
      end
      step();
    end
    vectors++;
    if (req_seen != r0) begin miscompares++; $display("FAIL sat_request got %0d pulses exp 0", req_seen - r0); end
    load_start_i = 1'b1; step(); load_start_i = 1'b0;
    vectors++;
    if (sat_o !== 1'b0 || setup_o !== 1'b1) begin
      miscompares++; $display("FAIL sat_exit sat %b setup %b exp 0 1", sat_o, setup_o);
    end
    load_done_i = 1'b1; step(); load_done_i = 1'b0;
    step();
  endtask

  task automatic test_overflow();
    ucb_overflow_i = 1'b1; step(); ucb_overflow_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (overflow_err_o !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky%0d got %b exp 1", i, overflow_err_o); end
      step();
    end
    load_start_i = 1'b1; step(); load_start_i = 1'b0;
    vectors++;
    if (overflow_err_o !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b exp 0", overflow_err_o); end
    load_done_i = 1'b1; step(); load_done_i = 1'b0;
    step();
  endtask

  task automatic test_reset_wait();
    int bad = 0;
    buffer_count_i = AW'(3);
    send_req(36'h0DEADBEEF);
    step(); step();
    reset = 1'b1; step(); reset = 1'b0;
    exp_q.delete();
    vectors++;
    if (busy_o !== 1'b1 || sel_valid_o !== 1'b0 || request_o !== 1'b0 || sel_clause_o !== '0) begin
      miscompares++; $display("FAIL rst_wait busy %b valid %b req %b clause %h exp 1 0 0 0", busy_o, sel_valid_o, request_o, sel_clause_o);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      if (sel_valid_o !== 1'b0 || busy_o !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL rst_dropped got %0d bad cycles exp 0", bad); end
    quick_load();
  endtask

  initial begin
    reset = 1'b1;
    {load_start_i, load_valid_i, load_done_i, sel_req_i, sel_ready_i, wd_req_i, ucb_overflow_i} = '0;
    load_addr_i = '0; load_data_i = '0; buffer_count_i = '0;
    test_reset();
    test_load();
    test_select();
    test_write_disable();
    test_back_to_back();
    test_sat();
    test_overflow();
    test_reset_wait();
    test_select();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors exp completion", vectors);
    $fatal(1, "timeout");
  end

endmodule
